sonic_eth_10g_mac_rx_stat_collector: RTL and testbench
======================================================

Name: sonic_eth_10g_mac_rx_stat_collector

Overview:
- Consumer end of the RX MAC statistics stream: takes one per-frame stat beat (valid, 40-bit frame descriptor, 7-bit remapped error vector) and accumulates per-category frame and octet counters.
- Counters are exposed to the host through a small CSR read/clear port.
- Sits after the RX stat error adapter, in the same clock domain as the MAC RX datapath.

Parameters:
- CNT_W, 32: width of each frame counter (8..32); read data is zero-extended to 32 bits.
- OCT_W, 64: width of the octet counter (33..64); read as lo/hi 32-bit words.

Ports:
- clk  input  1  datapath/CSR clock
- reset_n  input  1  reset; asynchronous assert, active-low
- in_valid  input  1  one stat beat per received frame
- in_data  input  40  [15:0] frame length bytes, [16] unicast, [17] multicast, [18] broadcast, [19] pause, [39:20] ignored
- in_error  input  7  [0] undersize, [1] oversize, [2] payload_length, [3] crc, [6] phy, [5:4] ignored
- csr_address  input  4  word address
- csr_read  input  1  read strobe
- csr_write  input  1  write strobe
- csr_writedata  input  32  write data
- csr_readdata  output  32  read data
- csr_readdatavalid  output  1  high one cycle after an accepted csr_read

Behaviour:
- Reset: all counters, pipeline registers, octet-hi snapshot, csr_readdata and csr_readdatavalid go to 0.
- Stage 1: register in_valid/in_data/in_error. Stage 2: decode and increment. A beat sampled at edge N is visible to reads issued at edge N+2 or later.
- err_any = |{in_error[6], in_error[3:0]}; frame_ok = !err_any.
- On each valid beat:
  - frames_total += 1.
  - frame_ok: frames_ok += 1 and octets_ok += length. Also unicast/multicast/broadcast/pause += 1 for each flag set; flags are counted independently.
  - Otherwise frames_err += 1, plus each of crc/undersize/oversize/payload_len/phy += 1 per set bit; several can increment in one beat.
- Address map:
  - 0 frames_ok, 1 frames_err, 2 crc_err, 3 undersize, 4 oversize, 5 payload_len_err, 6 phy_err.
  - 7 unicast_ok, 8 multicast_ok, 9 broadcast_ok, 10 pause_ok.
  - 11 octets_ok[31:0]; this read also latches octets_ok[OCT_W-1:32] into the hi snapshot.
  - 12 hi snapshot, 13 frames_total, 14 reads 0.
  - 15 control: reads 0; write with bit0=1 clears all counters and the snapshot.
- Read: csr_read sampled at edge N gives csr_readdata and csr_readdatavalid=1 after edge N (one-cycle latency). Back-to-back reads are allowed every cycle. csr_readdata holds its last value when csr_readdatavalid=0.
- Read and increment in the same cycle: the read returns the pre-increment value.
- csr_read and csr_write in the same cycle: both are performed. The read returns the pre-clear value.
- Clear and stage-2 beat in the same cycle: clear wins and that beat is discarded. A beat in stage 1 at clear time is counted normally afterwards.
- Counter overflow: wraps modulo 2^CNT_W (octets modulo 2^OCT_W), unless the optional feature is enabled.
- Writes to addresses 0..14 are ignored.
- Reset mid-stream: an asynchronous reset_n low immediately zeroes everything, including the in-flight pipeline beats.

Optional Feature:
- Macro SONIC_RX_STAT_SATURATE_EN.
- Defined: every counter saturates at all-ones and stays there until cleared or reset. The octet counter clamps to all-ones if the sum would exceed its range.
- Undefined: all counters wrap modulo their width.

Decomposition:
- Shared package: field-index localparams for in_data flags and in_error bits, CSR address constants (ADDR_FRAMES_OK..ADDR_CTRL), CLEAR bit index.
- One natural sub-module: sonic_eth_stat_counter (parameterised width, inc enable, increment amount, clear, saturate option). It is instantiated once per counter, including the octet counter with an amount input.

Test Plan:
- Reset, then read all 16 addresses -> every csr_readdata = 0, csr_readdatavalid high exactly one cycle after each csr_read.
- 3 good beats, length 64/1518/100 with unicast=1 -> frames_ok=3, unicast_ok=3, octets lo=1682, hi snapshot=0, frames_total=3, frames_err=0.
- One beat with in_error=7'b1001001 (phy, crc, undersize) -> frames_err=1, phy_err=1, crc_err=1, undersize=1, frames_ok=0, octets unchanged. Then in_error=7'b0110000 -> counted as frames_ok (reserved bits ignored).
- Stat beat at edge N and read of addr 0 at edge N+1 -> returns old value; read at edge N+2 -> returns incremented value.
- Write addr 15 with bit0=1 in the same cycle a beat is in stage 2 -> all counters 0 afterward, that beat not counted.
- Preload via 2^CNT_W+1 beats (small CNT_W=8 build) -> frames_ok=1 without macro, 255 with SONIC_RX_STAT_SATURATE_EN.

Source files
------------

// File: rtl/sonic_eth_10g_mac_rx_stat_collector_pkg.sv
// Shared field indices, CSR map and beat type for the RX statistics collector.
package sonic_eth_10g_mac_rx_stat_collector_pkg;

  localparam int IN_DATA_W = 40;
  localparam int IN_ERR_W  = 7;
  localparam int LEN_W     = 16;

  localparam int FLAG_UNICAST   = 16;
  localparam int FLAG_MULTICAST = 17;
  localparam int FLAG_BROADCAST = 18;
  localparam int FLAG_PAUSE     = 19;

  localparam int ERR_UNDERSIZE   = 0;
  localparam int ERR_OVERSIZE    = 1;
  localparam int ERR_PAYLOAD_LEN = 2;
  localparam int ERR_CRC         = 3;
  localparam int ERR_PHY         = 6;

  localparam logic [3:0] ADDR_FRAMES_OK    = 4'd0;
  localparam logic [3:0] ADDR_FRAMES_ERR   = 4'd1;
  localparam logic [3:0] ADDR_CRC_ERR      = 4'd2;
  localparam logic [3:0] ADDR_UNDERSIZE    = 4'd3;
  localparam logic [3:0] ADDR_OVERSIZE     = 4'd4;
  localparam logic [3:0] ADDR_PAYLOAD_LEN  = 4'd5;
  localparam logic [3:0] ADDR_PHY_ERR      = 4'd6;
  localparam logic [3:0] ADDR_UNICAST_OK   = 4'd7;
  localparam logic [3:0] ADDR_MULTICAST_OK = 4'd8;
  localparam logic [3:0] ADDR_BROADCAST_OK = 4'd9;
  localparam logic [3:0] ADDR_PAUSE_OK     = 4'd10;
  localparam logic [3:0] ADDR_OCT_LO       = 4'd11;
  localparam logic [3:0] ADDR_OCT_HI       = 4'd12;
  localparam logic [3:0] ADDR_FRAMES_TOTAL = 4'd13;
  localparam logic [3:0] ADDR_RSVD         = 4'd14;
  localparam logic [3:0] ADDR_CTRL         = 4'd15;

  localparam int CLEAR_BIT = 0;

  // Category counters occupy CSR addresses 0..NUM_CAT-1 directly.
  localparam int NUM_CAT = 11;

  typedef struct packed {
    logic phy;
    logic crc;
    logic payload_len;
    logic oversize;
    logic undersize;
  } stat_err_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             unicast;
    logic             multicast;
    logic             broadcast;
    logic             pause;
    stat_err_t        err;
  } stat_beat_t;

  function automatic logic err_any(input stat_err_t e);
    return |e;
  endfunction

endpackage

// File: rtl/sonic_eth_stat_counter.sv
// Single statistics counter: clear has priority over increment; optional saturation at all-ones.
module sonic_eth_stat_counter #(
  parameter int W     = 32,
  parameter int AMT_W = 1,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [W-1:0]     cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  assign sum = {1'b0, cnt_q} + (W+1)'(amt_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (SAT && sum[W]) cnt_d = '1;
      else               cnt_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sonic_eth_10g_mac_rx_stat_collector.sv
// RX MAC statistics collector: two-stage beat pipeline feeding per-category counters behind a CSR port.
// Define SONIC_RX_STAT_SATURATE_EN to make all counters saturate instead of wrap.
import sonic_eth_10g_mac_rx_stat_collector_pkg::*;

module sonic_eth_10g_mac_rx_stat_collector #(
  parameter int CNT_W = 32,
  parameter int OCT_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [IN_DATA_W-1:0] in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  input  logic [3:0]           csr_address,
  input  logic                 csr_read,
  input  logic                 csr_write,
  input  logic [31:0]          csr_writedata,
  output logic [31:0]          csr_readdata,
  output logic                 csr_readdatavalid
);

`ifdef SONIC_RX_STAT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  stat_beat_t beat_in, s1_beat_q;
  logic       s1_valid_q;

  assign beat_in.len             = in_data[LEN_W-1:0];
  assign beat_in.unicast         = in_data[FLAG_UNICAST];
  assign beat_in.multicast       = in_data[FLAG_MULTICAST];
  assign beat_in.broadcast       = in_data[FLAG_BROADCAST];
  assign beat_in.pause           = in_data[FLAG_PAUSE];
  assign beat_in.err.phy         = in_error[ERR_PHY];
  assign beat_in.err.crc         = in_error[ERR_CRC];
  assign beat_in.err.payload_len = in_error[ERR_PAYLOAD_LEN];
  assign beat_in.err.oversize    = in_error[ERR_OVERSIZE];
  assign beat_in.err.undersize   = in_error[ERR_UNDERSIZE];

  logic unused_ok;
  assign unused_ok = ^{in_data[IN_DATA_W-1:FLAG_PAUSE+1], in_error[5:4], csr_writedata[31:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_beat_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_beat_q  <= beat_in;
    end
  end

  logic clr, beat_ok, beat_bad;
  assign clr      = csr_write && (csr_address == ADDR_CTRL) && csr_writedata[CLEAR_BIT];
  assign beat_ok  = s1_valid_q && !err_any(s1_beat_q.err);
  assign beat_bad = s1_valid_q &&  err_any(s1_beat_q.err);

  logic [NUM_CAT-1:0] cat_inc;
  always_comb begin
    cat_inc                    = '0;
    cat_inc[ADDR_FRAMES_OK]    = beat_ok;
    cat_inc[ADDR_FRAMES_ERR]   = beat_bad;
    cat_inc[ADDR_CRC_ERR]      = beat_bad && s1_beat_q.err.crc;
    cat_inc[ADDR_UNDERSIZE]    = beat_bad && s1_beat_q.err.undersize;
    cat_inc[ADDR_OVERSIZE]     = beat_bad && s1_beat_q.err.oversize;
    cat_inc[ADDR_PAYLOAD_LEN]  = beat_bad && s1_beat_q.err.payload_len;
    cat_inc[ADDR_PHY_ERR]      = beat_bad && s1_beat_q.err.phy;
    cat_inc[ADDR_UNICAST_OK]   = beat_ok && s1_beat_q.unicast;
    cat_inc[ADDR_MULTICAST_OK] = beat_ok && s1_beat_q.multicast;
    cat_inc[ADDR_BROADCAST_OK] = beat_ok && s1_beat_q.broadcast;
    cat_inc[ADDR_PAUSE_OK]     = beat_ok && s1_beat_q.pause;
  end

  logic [CNT_W-1:0] cat_cnt [NUM_CAT];
  logic [CNT_W-1:0] total_cnt;
  logic [OCT_W-1:0] oct_cnt;

  for (genvar g = 0; g < NUM_CAT; g++) begin : g_cat
    sonic_eth_stat_counter #(.W(CNT_W), .AMT_W(1), .SAT(SAT)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (clr),
      .inc_i   (cat_inc[g]),
      .amt_i   (1'b1),
      .cnt_o   (cat_cnt[g])
    );
  end

  sonic_eth_stat_counter #(.W(CNT_W), .AMT_W(1), .SAT(SAT)) u_total (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .inc_i   (s1_valid_q),
    .amt_i   (1'b1),
    .cnt_o   (total_cnt)
  );

  sonic_eth_stat_counter #(.W(OCT_W), .AMT_W(LEN_W), .SAT(SAT)) u_octets (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .inc_i   (beat_ok),
    .amt_i   (s1_beat_q.len),
    .cnt_o   (oct_cnt)
  );

  logic [OCT_W-33:0] oct_hi_q;
  logic [31:0]       rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      if (csr_address == 4'(i)) rd_mux = 32'(cat_cnt[i]);
    end
    case (csr_address)
      ADDR_OCT_LO:       rd_mux = oct_cnt[31:0];
      ADDR_OCT_HI:       rd_mux = 32'(oct_hi_q);
      ADDR_FRAMES_TOTAL: rd_mux = 32'(total_cnt);
      default:           ;
    endcase
  end

  // Reading the low octet word freezes the high word so a lo/hi pair is coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
      oct_hi_q          <= '0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) csr_readdata <= rd_mux;
      if (clr)
        oct_hi_q <= '0;
      else if (csr_read && (csr_address == ADDR_OCT_LO))
        oct_hi_q <= oct_cnt[OCT_W-1:32];
    end
  end

endmodule

// File: tb/tb_sonic_eth_10g_mac_rx_stat_collector.sv
// Randomized self-checking bench for the RX stat collector against a per-category count model.
module tb_sonic_eth_10g_mac_rx_stat_collector;

  localparam int CNT_W = 8;
  localparam int OCT_W = 40;
`ifdef SONIC_RX_STAT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [39:0] in_data = '0;
  logic [6:0]  in_error = '0;
  logic [3:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        csr_readdatavalid;

  int n_checks = 0;
  int n_fail   = 0;

  // Unbounded event counts indexed by CSR address; width effects applied on compare.
  longint m_cnt [16];
  longint m_oct;
  longint m_snap;

  sonic_eth_10g_mac_rx_stat_collector #(.CNT_W(CNT_W), .OCT_W(OCT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_error),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint cap(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (SAT) return (c > mx) ? mx : c;
    return c & mx;
  endfunction

  function automatic logic [31:0] exp_val(input int a);
    case (a)
      11:      return 32'(cap(m_oct, OCT_W));
      12:      return 32'(m_snap);
      14, 15:  return '0;
      default: return 32'(cap(m_cnt[a], CNT_W));
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_oct  = 0;
    m_snap = 0;
  endtask

  task automatic model_beat(input logic [15:0] len, input logic [3:0] flags, input logic [6:0] err);
    m_cnt[13]++;
    if (err[6] || err[3] || err[2] || err[1] || err[0]) begin
      m_cnt[1]++;
      if (err[3]) m_cnt[2]++;
      if (err[0]) m_cnt[3]++;
      if (err[1]) m_cnt[4]++;
      if (err[2]) m_cnt[5]++;
      if (err[6]) m_cnt[6]++;
    end else begin
      m_cnt[0]++;
      m_oct += longint'(len);
      for (int f = 0; f < 4; f++) if (flags[f]) m_cnt[7+f]++;
    end
  endtask

  task automatic set_beat(input logic [15:0] len, input logic [3:0] flags, input logic [6:0] err);
    in_valid = 1'b1;
    in_data  = {20'($urandom), flags, len};
    in_error = err;
  endtask

  task automatic drive_beat(input logic [15:0] len, input logic [3:0] flags, input logic [6:0] err);
    set_beat(len, flags, err);
    model_beat(len, flags, err);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input int a, output logic [31:0] d, output logic v);
    csr_read    = 1'b1;
    csr_address = 4'(a);
    @(negedge clk);
    d = csr_readdata;
    v = csr_readdatavalid;
    csr_read = 1'b0;
    if (a == 11) m_snap = cap(m_oct, OCT_W) >> 32;
  endtask

  task automatic do_write(input int a, input logic [31:0] wd);
    csr_write     = 1'b1;
    csr_address   = 4'(a);
    csr_writedata = wd;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (csr_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdvalid: got %b expected 0", csr_readdatavalid);
    end
    for (int a = 0; a < 16; a++) begin
      csr_read    = 1'b1;
      csr_address = 4'(a);
      @(negedge clk);
      e = exp_val(a);
      if (a == 11) m_snap = cap(m_oct, OCT_W) >> 32;
      n_checks++;
      if (csr_readdata !== e) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h expected %h", a, csr_readdata, e);
      end
      n_checks++;
      if (csr_readdatavalid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_rdvalid[%0d]: got %b expected 1", a, csr_readdatavalid);
      end
    end
    csr_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (csr_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdvalid_drop: got %b expected 0", csr_readdatavalid);
    end
  endtask

  task automatic test_good_frames();
    int          addrs [6] = '{0, 1, 7, 11, 12, 13};
    logic [31:0] d;
    logic        v;
    drive_beat(16'd64,   4'b0001, 7'b0);
    drive_beat(16'd1518, 4'b0001, 7'b0);
    drive_beat(16'd100,  4'b0001, 7'b0);
    idle(3);
    foreach (addrs[i]) begin
      do_read(addrs[i], d, v);
      n_checks++;
      if (d !== exp_val(addrs[i]) || v !== 1'b1) begin
        n_fail++;
        $display("FAIL good_read[%0d]: got %h/%b expected %h/1", addrs[i], d, v, exp_val(addrs[i]));
      end
    end
  endtask

  task automatic test_error_frames();
    logic [31:0] d;
    logic        v;
    drive_beat(16'($urandom), 4'($urandom), 7'b1001001);
    idle(3);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL err_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
    drive_beat(16'($urandom), 4'($urandom), 7'b0110000);
    idle(3);
    for (int a = 0; a < 2; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL rsvd_err_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
    do_read(11, d, v);
    n_checks++;
    if (d !== exp_val(11)) begin
      n_fail++;
      $display("FAIL rsvd_err_oct: got %h expected %h", d, exp_val(11));
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] old_v, d1, d2;
    logic [15:0] len;
    logic [3:0]  flags;
    len   = 16'($urandom_range(60, 1500));
    flags = 4'($urandom);
    old_v = exp_val(0);
    set_beat(len, flags, 7'b0);
    @(negedge clk);
    in_valid    = 1'b0;
    csr_read    = 1'b1;
    csr_address = 4'd0;
    @(negedge clk);
    d1 = csr_readdata;
    model_beat(len, flags, 7'b0);
    @(negedge clk);
    d2 = csr_readdata;
    csr_read = 1'b0;
    n_checks++;
    if (d1 !== old_v) begin
      n_fail++;
      $display("FAIL latency_n1: got %h expected %h", d1, old_v);
    end
    n_checks++;
    if (d2 !== exp_val(0)) begin
      n_fail++;
      $display("FAIL latency_n2: got %h expected %h", d2, exp_val(0));
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        v;
    logic [6:0]  err;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        err = 7'($urandom);
        if ($urandom_range(0, 1) == 0) err = err & 7'b0110000;
        drive_beat(16'($urandom), 4'($urandom), err);
      end
    end
    idle(3);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL random_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
  endtask

  task automatic test_clear_collision();
    logic [31:0] d;
    logic        v;
    logic [15:0] len_b;
    logic [3:0]  flg_b;
    logic [6:0]  err_b;
    do_write($urandom_range(0, 14), $urandom | 32'h1);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL ignored_write[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
    set_beat(16'd200, 4'b1111, 7'b0);
    @(negedge clk);
    len_b = 16'($urandom);
    flg_b = 4'($urandom);
    err_b = 7'($urandom);
    set_beat(len_b, flg_b, err_b);
    csr_write     = 1'b1;
    csr_read      = 1'b1;
    csr_address   = 4'd15;
    csr_writedata = $urandom | 32'h1;
    @(negedge clk);
    csr_write = 1'b0;
    csr_read  = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (csr_readdata !== 32'h0 || csr_readdatavalid !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_read: got %h/%b expected 00000000/1", csr_readdata, csr_readdatavalid);
    end
    model_clear();
    model_beat(len_b, flg_b, err_b);
    idle(3);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL clear_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        v;
    do_write(15, 32'h1);
    model_clear();
    for (int i = 0; i < (1 << CNT_W) + 1; i++) drive_beat(16'($urandom_range(0, 255)), 4'($urandom), 7'b0);
    idle(3);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL overflow_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    logic        v;
    set_beat(16'd77, 4'b0010, 7'b0);
    csr_read    = 1'b1;
    csr_address = 4'd13;
    @(negedge clk);
    set_beat(16'd88, 4'b0100, 7'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (csr_readdata !== 32'h0 || csr_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%b expected 00000000/0", csr_readdata, csr_readdatavalid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    csr_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    idle(3);
    for (int a = 0; a < 16; a++) begin
      do_read(a, d, v);
      n_checks++;
      if (d !== exp_val(a)) begin
        n_fail++;
        $display("FAIL midreset_read[%0d]: got %h expected %h", a, d, exp_val(a));
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_good_frames();
    test_error_frames();
    test_read_latency();
    test_random();
    test_clear_collision();
    test_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
